pic_ack_sequencer: RTL and testbench
====================================

Name: pic_ack_sequencer

Overview:
Control sequencer for the in-service path of the 8259-compatible PIC. Resolves the pending request against the current highest in-service level and the rotation state, then raises INT. It runs the 2-pulse (8086) or 3-pulse (8080) INTA sequence and drives latch/EOI/rotate controls into the in-service block. It also decodes OCW2 commands: EOI variants, rotation and set-priority.

Parameters:
NUM_IR, 8, number of interrupt levels; fixed at 8, widths below assume 8.
SPURIOUS_LEVEL, 7, level reported when first INTA finds no valid request.

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
interrupt_request  in  8  IRR contents
interrupt_mask  in  8  IMR; 1 = masked
highest_level_in_service  in  8  one-hot highest ISR bit (0 = none)
int_ack_begin  in  1  one-cycle strobe, INTA falling edge (synchronised upstream)
int_ack_end  in  1  one-cycle strobe, INTA rising edge
mode_8086  in  1  1 = 2-pulse sequence, 0 = 3-pulse 8080 sequence
auto_eoi  in  1  ICW4 AEOI
ocw2_write  in  1  one-cycle strobe, OCW2 written
ocw2_data  in  8  [7]=R, [6]=SL, [5]=EOI, [2:0]=L
int_out  out  1  INT to CPU
interrupt  out  8  one-hot level being acknowledged, to ISR set
latch_in_service  out  1  one-cycle ISR set strobe
clear_request  out  8  one-cycle IRR clear mask
end_of_interrupt  out  8  one-cycle ISR clear mask
priority_rotate  out  3  lowest-priority level; highest = rotate+1 mod 8
ack_phase  out  2  0 idle, 1 first, 2 second, 3 third INTA (data-bus mux select)
spurious  out  1  high from first INTA until IDLE when no valid request

Behaviour:
- Reset values: int_out 0, interrupt 0, latch_in_service 0, clear_request 0, end_of_interrupt 0, priority_rotate 7, ack_phase 0, spurious 0, rotate_on_aeoi 0, state IDLE. Reset mid-sequence aborts to IDLE with no EOI or latch pulses.
- Resolver (combinational): rotate (IRR & ~IMR) and highest_level_in_service right by priority_rotate+1, take the lowest set bit, rotate back. A request is valid only if its rotated position is strictly below the rotated ISR position, or ISR is 0.
- int_out is registered: set 1 cycle after a valid request appears in IDLE, cleared on entry to ACK1. It is not reasserted until IDLE.
- States: IDLE, ACK1, WAIT2, ACK2, WAIT3, ACK3.
- IDLE: int_ack_begin with int_out=1 -> ACK1.
  - Same cycle, when valid: register interrupt = resolved one-hot, pulse latch_in_service and clear_request = interrupt.
  - When no valid request: interrupt = 0, no latch/clear, spurious = 1; level reported is SPURIOUS_LEVEL.
  - int_ack_begin with int_out=0 is ignored.
- ACK1: ack_phase=1; int_ack_end -> WAIT2.
- WAIT2: int_ack_begin -> ACK2.
- ACK2: ack_phase=2; int_ack_end -> IDLE if mode_8086, else WAIT3.
- WAIT3: int_ack_begin -> ACK3.
- ACK3: ack_phase=3; int_ack_end -> IDLE.
- Final int_ack_end with auto_eoi=1 and spurious=0:
  - Pulse end_of_interrupt = interrupt for 1 cycle.
  - If rotate_on_aeoi, priority_rotate <= index(interrupt).
- interrupt and spurious clear on return to IDLE.
- OCW2 decode on ocw2_write, with {R,SL,EOI}:
  - 001 non-specific EOI: end_of_interrupt = highest_level_in_service.
  - 011 specific EOI: end_of_interrupt = onehot(L).
  - 101 rotate on NS-EOI: as 001, plus priority_rotate = index(highest_level_in_service). When highest_level_in_service = 0: no EOI bits and no rotate.
  - 111 rotate on specific EOI: end_of_interrupt = onehot(L), priority_rotate = L.
  - 110 set priority: priority_rotate = L.
  - 100: rotate_on_aeoi <= 1. 000: rotate_on_aeoi <= 0. 010: no-op.
- EOI/latch outputs are registered, 1-cycle latency from the causing strobe, and high exactly one cycle.
- Simultaneous OCW2 EOI and AEOI: end_of_interrupt is the OR of both masks; the OCW2 rotate value wins.
- int_ack_begin/end outside their expected states are ignored. No timeout.

Test Plan:
- Reset then IRR=0x00 -> int_out 0, priority_rotate 7. IRR=0x24, IMR=0 -> int_out 1 next cycle; 8086 sequence -> interrupt=0x04, latch and clear_request=0x04 pulsed once, ack_phase 1,2,0.
- ISR highest=0x04, IRR=0x10 -> int_out stays 0. IRR=0x02 -> int_out 1.
- mode_8086=0, auto_eoi=1, IRR=0x80 -> three INTA pulses, ack_phase 1,2,3; end_of_interrupt=0x80 one cycle after third int_ack_end.
- OCW2 0xA0 with highest=0x08 -> end_of_interrupt=0x08, priority_rotate=3. Then IRR=0x09 -> resolves 0x01 first (level 4 highest is absent, wraps to 0).
- Request withdrawn (IRR->0) after int_out before int_ack_begin -> spurious=1, interrupt=0, no latch, no EOI even with auto_eoi=1.
- Reset asserted in ACK2 -> next cycle state IDLE, all outputs reset values, no end_of_interrupt pulse.

Source files
------------

// File: rtl/pic_ack_sequencer.sv
// pic_ack_sequencer
//
// Control sequencer for the in-service path of an 8259-compatible PIC.
// Picks the winning request against the current highest in-service level and
// the rotation state, raises INT, walks the 2-pulse (8086) or 3-pulse (8080)
// INTA sequence, and drives latch/clear/EOI/rotate controls into the
// in-service block. OCW2 commands (EOI variants, rotation, set-priority) are
// decoded here as well.
//
// Ports:
//   clock, reset               system clock, synchronous active-high reset
//   interrupt_request   [7:0]  IRR contents
//   interrupt_mask      [7:0]  IMR, 1 = masked
//   highest_level_in_service   one-hot highest ISR bit, 0 = none
//   int_ack_begin / _end       one-cycle strobes on INTA falling / rising edge
//   mode_8086                  1 = 2-pulse sequence, 0 = 3-pulse sequence
//   auto_eoi                   automatic EOI on the last INTA
//   ocw2_write, ocw2_data      OCW2 strobe and data {R,SL,EOI,x,x,L[2:0]}
//   int_out                    INT to the CPU
//   interrupt           [7:0]  one-hot level being acknowledged
//   latch_in_service           one-cycle ISR set strobe
//   clear_request       [7:0]  one-cycle IRR clear mask
//   end_of_interrupt    [7:0]  one-cycle ISR clear mask
//   priority_rotate     [2:0]  lowest-priority level (highest = rotate+1)
//   ack_phase           [1:0]  0 idle/between pulses, 1..3 INTA pulse number
//   spurious                   acknowledge found no valid request
//   ack_level           [2:0]  level index for the vector (SPURIOUS_LEVEL
//                              when spurious)
//   debug_state         [2:0]  current sequencer state
//
// Handshake: there is no valid/ready pair here. Every input strobe is a
// single-cycle pulse that is acted on in the cycle it is high, and only in
// the state that expects it; every output pulse is registered and lasts
// exactly one cycle.

module pic_ack_sequencer #(
    parameter int         NUM_IR         = 8,
    parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_IR-1:0] interrupt_request,
    input  logic [NUM_IR-1:0] interrupt_mask,
    input  logic [NUM_IR-1:0] highest_level_in_service,
    input  logic              int_ack_begin,
    input  logic              int_ack_end,
    input  logic              mode_8086,
    input  logic              auto_eoi,
    input  logic              ocw2_write,
    input  logic [7:0]        ocw2_data,
    output logic              int_out,
    output logic [NUM_IR-1:0] interrupt,
    output logic              latch_in_service,
    output logic [NUM_IR-1:0] clear_request,
    output logic [NUM_IR-1:0] end_of_interrupt,
    output logic [2:0]        priority_rotate,
    output logic [1:0]        ack_phase,
    output logic              spurious,
    output logic [2:0]        ack_level,
    output logic [2:0]        debug_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACK1  = 3'd1,
        S_WAIT2 = 3'd2,
        S_ACK2  = 3'd3,
        S_WAIT3 = 3'd4,
        S_ACK3  = 3'd5
    } state_t;

    state_t state;
    logic   rotate_on_aeoi;

    assign debug_state = state;

    // OCW2 bits [4:3] select the OCW type upstream and carry no meaning here.
    logic unused_ocw2_bits;
    assign unused_ocw2_bits = ^ocw2_data[4:3];

    function automatic logic [2:0] onehot_index(input logic [NUM_IR-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_IR; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // Resolver. Rotating right by priority_rotate+1 puts the highest
    // priority level at bit 0, so "lowest set bit" is "highest priority".
    // ------------------------------------------------------------------
    logic [NUM_IR-1:0]   pending;
    logic [2:0]          shift;
    logic [2*NUM_IR-1:0] req_dbl;
    logic [2*NUM_IR-1:0] isr_dbl;
    logic                req_any;
    logic                isr_any;
    logic [2:0]          req_pos;
    logic [2:0]          isr_pos;
    logic                req_valid;
    logic [2:0]          res_idx;
    logic [NUM_IR-1:0]   res_onehot;

    always_comb begin
        pending = interrupt_request & ~interrupt_mask;
        shift   = priority_rotate + 3'd1;
        req_dbl = {pending, pending} >> shift;
        isr_dbl = {highest_level_in_service, highest_level_in_service} >> shift;
        req_any = 1'b0;
        isr_any = 1'b0;
        req_pos = '0;
        isr_pos = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (req_dbl[i]) begin
                req_any = 1'b1;
                req_pos = 3'(i);
            end
            if (isr_dbl[i]) begin
                isr_any = 1'b1;
                isr_pos = 3'(i);
            end
        end
        // A request equal to or below the in-service level must wait.
        req_valid  = req_any && (!isr_any || (req_pos < isr_pos));
        res_idx    = req_pos + shift;
        res_onehot = '0;
        res_onehot[res_idx] = 1'b1;
    end

    // ------------------------------------------------------------------
    // OCW2 decode on {R,SL,EOI}
    // ------------------------------------------------------------------
    logic [NUM_IR-1:0] ocw_eoi;
    logic [NUM_IR-1:0] ocw_l_onehot;
    logic              ocw_rot_en;
    logic [2:0]        ocw_rot_val;
    logic              raeoi_set;
    logic              raeoi_clr;

    always_comb begin
        ocw_eoi      = '0;
        ocw_l_onehot = '0;
        ocw_l_onehot[ocw2_data[2:0]] = 1'b1;
        ocw_rot_en   = 1'b0;
        ocw_rot_val  = ocw2_data[2:0];
        raeoi_set    = 1'b0;
        raeoi_clr    = 1'b0;
        if (ocw2_write) begin
            case (ocw2_data[7:5])
                3'b001: ocw_eoi = highest_level_in_service;
                3'b011: ocw_eoi = ocw_l_onehot;
                3'b101: begin
                    // Rotate on non-specific EOI needs something in service.
                    if (|highest_level_in_service) begin
                        ocw_eoi     = highest_level_in_service;
                        ocw_rot_en  = 1'b1;
                        ocw_rot_val = onehot_index(highest_level_in_service);
                    end
                end
                3'b111: begin
                    ocw_eoi    = ocw_l_onehot;
                    ocw_rot_en = 1'b1;
                end
                3'b110:  ocw_rot_en = 1'b1;
                3'b100:  raeoi_set  = 1'b1;
                3'b000:  raeoi_clr  = 1'b1;
                default: ;
            endcase
        end
    end

    // Last INTA pulse of the sequence, where automatic EOI takes effect.
    logic final_end;
    logic aeoi_fire;

    always_comb begin
        final_end = int_ack_end &&
                    (((state == S_ACK2) && mode_8086) || (state == S_ACK3));
        aeoi_fire = final_end && auto_eoi && !spurious;
    end

    // ------------------------------------------------------------------
    // Sequencer with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= S_IDLE;
            int_out          <= 1'b0;
            interrupt        <= '0;
            latch_in_service <= 1'b0;
            clear_request    <= '0;
            end_of_interrupt <= '0;
            priority_rotate  <= 3'd7;
            ack_phase        <= 2'd0;
            spurious         <= 1'b0;
            ack_level        <= '0;
            rotate_on_aeoi   <= 1'b0;
        end else begin
            latch_in_service <= 1'b0;
            clear_request    <= '0;
            end_of_interrupt <= ocw_eoi | (aeoi_fire ? interrupt : '0);

            // An explicit OCW2 rotate overrides the automatic one.
            if (ocw_rot_en) begin
                priority_rotate <= ocw_rot_val;
            end else if (aeoi_fire && rotate_on_aeoi) begin
                priority_rotate <= onehot_index(interrupt);
            end

            if (raeoi_set) begin
                rotate_on_aeoi <= 1'b1;
            end else if (raeoi_clr) begin
                rotate_on_aeoi <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (int_ack_begin && int_out) begin
                        state     <= S_ACK1;
                        ack_phase <= 2'd1;
                        int_out   <= 1'b0;
                        if (req_valid) begin
                            interrupt        <= res_onehot;
                            latch_in_service <= 1'b1;
                            clear_request    <= res_onehot;
                            spurious         <= 1'b0;
                            ack_level        <= res_idx;
                        end else begin
                            // Request vanished between INT and INTA.
                            interrupt <= '0;
                            spurious  <= 1'b1;
                            ack_level <= SPURIOUS_LEVEL;
                        end
                    end else if (req_valid) begin
                        // INT stays up once raised, even if IRR drops.
                        int_out <= 1'b1;
                    end
                end
                S_ACK1: begin
                    if (int_ack_end) begin
                        state     <= S_WAIT2;
                        ack_phase <= 2'd0;
                    end
                end
                S_WAIT2: begin
                    if (int_ack_begin) begin
                        state     <= S_ACK2;
                        ack_phase <= 2'd2;
                    end
                end
                S_ACK2: begin
                    if (int_ack_end) begin
                        ack_phase <= 2'd0;
                        if (mode_8086) begin
                            state     <= S_IDLE;
                            interrupt <= '0;
                            spurious  <= 1'b0;
                            ack_level <= '0;
                        end else begin
                            state <= S_WAIT3;
                        end
                    end
                end
                S_WAIT3: begin
                    if (int_ack_begin) begin
                        state     <= S_ACK3;
                        ack_phase <= 2'd3;
                    end
                end
                S_ACK3: begin
                    if (int_ack_end) begin
                        state     <= S_IDLE;
                        ack_phase <= 2'd0;
                        interrupt <= '0;
                        spurious  <= 1'b0;
                        ack_level <= '0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    ack_phase <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pic_ack_sequencer.sv
// Self-checking bench for pic_ack_sequencer: directed scenarios plus
// randomized acknowledge sequences and OCW2 commands compared against a
// priority-order reference model.

module tb_pic_ack_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irr = '0;
    logic [7:0] imr = '0;
    logic [7:0] isr = '0;
    logic       begin_s = 1'b0;
    logic       end_s = 1'b0;
    logic       mode_8086 = 1'b1;
    logic       auto_eoi = 1'b0;
    logic       ocw2_write = 1'b0;
    logic [7:0] ocw2_data = '0;

    logic       int_out;
    logic [7:0] interrupt;
    logic       latch_in_service;
    logic [7:0] clear_request;
    logic [7:0] end_of_interrupt;
    logic [2:0] priority_rotate;
    logic [1:0] ack_phase;
    logic       spurious;
    logic [2:0] ack_level;
    logic [2:0] debug_state;

    int total = 0;
    int bad = 0;

    // Reference state
    int model_rot = 7;
    bit model_raeoi = 1'b0;

    pic_ack_sequencer #(.NUM_IR(8), .SPURIOUS_LEVEL(3'd7)) dut (
        .clock                    (clock),
        .reset                    (reset),
        .interrupt_request        (irr),
        .interrupt_mask           (imr),
        .highest_level_in_service (isr),
        .int_ack_begin            (begin_s),
        .int_ack_end              (end_s),
        .mode_8086                (mode_8086),
        .auto_eoi                 (auto_eoi),
        .ocw2_write               (ocw2_write),
        .ocw2_data                (ocw2_data),
        .int_out                  (int_out),
        .interrupt                (interrupt),
        .latch_in_service         (latch_in_service),
        .clear_request            (clear_request),
        .end_of_interrupt         (end_of_interrupt),
        .priority_rotate          (priority_rotate),
        .ack_phase                (ack_phase),
        .spurious                 (spurious),
        .ack_level                (ack_level),
        .debug_state              (debug_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_rot = 7;
        model_raeoi = 1'b0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_begin();
        begin_s = 1'b1;
        tick();
        begin_s = 1'b0;
    endtask

    task automatic pulse_end();
        end_s = 1'b1;
        tick();
        end_s = 1'b0;
    endtask

    task automatic write_ocw2(input logic [7:0] d);
        ocw2_write = 1'b1;
        ocw2_data  = d;
        tick();
        ocw2_write = 1'b0;
    endtask

    // ---------------- reference model ----------------
    // Walk levels from highest to lowest priority; the in-service level
    // blocks itself and everything after it.
    function automatic int model_resolve(input logic [7:0] req, input logic [7:0] in_svc,
                                         input int rot);
        for (int k = 1; k <= 8; k++) begin
            int lvl;
            lvl = (rot + k) % 8;
            if (in_svc[lvl]) return -1;
            if (req[lvl]) return lvl;
        end
        return -1;
    endfunction

    function automatic int lowest_bit(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_ocw(input logic [7:0] d, input logic [7:0] in_svc,
                             output logic [7:0] mask, output bit rot_en, output int rot_val);
        logic [7:0] l_oh;
        l_oh    = 8'h01 << d[2:0];
        mask    = '0;
        rot_en  = 1'b0;
        rot_val = int'(d[2:0]);
        case (d[7:5])
            3'b001: mask = in_svc;
            3'b011: mask = l_oh;
            3'b101: if (in_svc != 0) begin
                mask = in_svc; rot_en = 1'b1; rot_val = lowest_bit(in_svc);
            end
            3'b111: begin mask = l_oh; rot_en = 1'b1; end
            3'b110: rot_en = 1'b1;
            3'b100: model_raeoi = 1'b1;
            3'b000: model_raeoi = 1'b0;
            default: ;
        endcase
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        irr = 8'h00;
        do_reset();
        total++; if (int_out !== 1'b0) begin bad++; $display("FAIL reset_int_out got=%0b exp=0", int_out); end
        total++; if (priority_rotate !== 3'd7) begin bad++; $display("FAIL reset_rotate got=%0d exp=7", priority_rotate); end
        total++; if ({interrupt, clear_request, end_of_interrupt} !== 24'h0 || latch_in_service !== 1'b0)
            begin bad++; $display("FAIL reset_masks int=%h clr=%h eoi=%h latch=%0b exp all 0", interrupt, clear_request, end_of_interrupt, latch_in_service); end
        total++; if (ack_phase !== 2'd0 || spurious !== 1'b0) begin bad++; $display("FAIL reset_phase phase=%0d spur=%0b exp 0/0", ack_phase, spurious); end
        tick();
        tick();
        total++; if (int_out !== 1'b0) begin bad++; $display("FAIL idle_no_req_int got=%0b exp=0", int_out); end
    endtask

    task automatic test_basic_8086();
        mode_8086 = 1'b1; auto_eoi = 1'b0; imr = 8'h00; isr = 8'h00;
        irr = 8'h24;
        tick();
        total++; if (int_out !== 1'b1) begin bad++; $display("FAIL basic_int_out got=%0b exp=1", int_out); end
        pulse_begin();
        total++; if (interrupt !== 8'h04 || clear_request !== 8'h04 || latch_in_service !== 1'b1)
            begin bad++; $display("FAIL basic_ack1 int=%h clr=%h latch=%0b exp 04/04/1", interrupt, clear_request, latch_in_service); end
        total++; if (ack_phase !== 2'd1 || int_out !== 1'b0) begin bad++; $display("FAIL basic_phase1 phase=%0d int_out=%0b exp 1/0", ack_phase, int_out); end
        tick();
        total++; if (latch_in_service !== 1'b0 || clear_request !== 8'h00)
            begin bad++; $display("FAIL basic_pulse_once latch=%0b clr=%h exp 0/00", latch_in_service, clear_request); end
        pulse_end();
        pulse_begin();
        total++; if (ack_phase !== 2'd2 || latch_in_service !== 1'b0) begin bad++; $display("FAIL basic_phase2 phase=%0d latch=%0b exp 2/0", ack_phase, latch_in_service); end
        pulse_end();
        irr = 8'h00;
        total++; if (ack_phase !== 2'd0 || interrupt !== 8'h00 || end_of_interrupt !== 8'h00)
            begin bad++; $display("FAIL basic_done phase=%0d int=%h eoi=%h exp 0/00/00", ack_phase, interrupt, end_of_interrupt); end
    endtask

    task automatic test_isr_block();
        isr = 8'h04; irr = 8'h10;
        tick(); tick();
        total++; if (int_out !== 1'b0) begin bad++; $display("FAIL isr_block_low got=%0b exp=0", int_out); end
        irr = 8'h02;
        tick();
        total++; if (int_out !== 1'b1) begin bad++; $display("FAIL isr_allow_high got=%0b exp=1", int_out); end
        pulse_begin();
        total++; if (interrupt !== 8'h02) begin bad++; $display("FAIL isr_allow_level got=%h exp=02", interrupt); end
        pulse_end(); pulse_begin(); pulse_end();
        irr = 8'h00; isr = 8'h00;
    endtask

    task automatic test_8080_aeoi();
        mode_8086 = 1'b0; auto_eoi = 1'b1;
        irr = 8'h80;
        tick();
        pulse_begin();
        total++; if (interrupt !== 8'h80 || ack_phase !== 2'd1) begin bad++; $display("FAIL p3_ack1 int=%h phase=%0d exp 80/1", interrupt, ack_phase); end
        pulse_end(); pulse_begin();
        total++; if (ack_phase !== 2'd2) begin bad++; $display("FAIL p3_phase2 got=%0d exp=2", ack_phase); end
        pulse_end();
        total++; if (end_of_interrupt !== 8'h00 || interrupt !== 8'h80)
            begin bad++; $display("FAIL p3_no_early_eoi eoi=%h int=%h exp 00/80", end_of_interrupt, interrupt); end
        pulse_begin();
        total++; if (ack_phase !== 2'd3) begin bad++; $display("FAIL p3_phase3 got=%0d exp=3", ack_phase); end
        pulse_end();
        irr = 8'h00;
        total++; if (end_of_interrupt !== 8'h80) begin bad++; $display("FAIL p3_aeoi got=%h exp=80", end_of_interrupt); end
        tick();
        total++; if (end_of_interrupt !== 8'h00 || priority_rotate !== 3'(model_rot))
            begin bad++; $display("FAIL p3_aeoi_once eoi=%h rot=%0d exp 00/%0d", end_of_interrupt, priority_rotate, model_rot); end
        mode_8086 = 1'b1; auto_eoi = 1'b0;
    endtask

    task automatic test_ocw2_rotate();
        isr = 8'h08;
        write_ocw2(8'hA0);
        model_rot = 3;
        total++; if (end_of_interrupt !== 8'h08 || priority_rotate !== 3'd3)
            begin bad++; $display("FAIL rot_nseoi eoi=%h rot=%0d exp 08/3", end_of_interrupt, priority_rotate); end
        isr = 8'h00; irr = 8'h09;
        tick();
        total++; if (end_of_interrupt !== 8'h00) begin bad++; $display("FAIL rot_nseoi_once got=%h exp=00", end_of_interrupt); end
        pulse_begin();
        total++; if (interrupt !== 8'h01) begin bad++; $display("FAIL rot_wrap got=%h exp=01", interrupt); end
        pulse_end(); pulse_begin(); pulse_end();
        irr = 8'h00;
        write_ocw2(8'hC7);
        model_rot = 7;
        total++; if (priority_rotate !== 3'd7) begin bad++; $display("FAIL set_priority got=%0d exp=7", priority_rotate); end
    endtask

    task automatic test_spurious();
        auto_eoi = 1'b1; mode_8086 = 1'b1;
        irr = 8'h10;
        tick();
        irr = 8'h00;
        tick();
        total++; if (int_out !== 1'b1) begin bad++; $display("FAIL spur_int_held got=%0b exp=1", int_out); end
        pulse_begin();
        total++; if (spurious !== 1'b1 || interrupt !== 8'h00 || latch_in_service !== 1'b0 || clear_request !== 8'h00)
            begin bad++; $display("FAIL spur_ack1 spur=%0b int=%h latch=%0b clr=%h exp 1/00/0/00", spurious, interrupt, latch_in_service, clear_request); end
        total++; if (ack_level !== 3'd7) begin bad++; $display("FAIL spur_level got=%0d exp=7", ack_level); end
        pulse_end(); pulse_begin(); pulse_end();
        total++; if (end_of_interrupt !== 8'h00 || spurious !== 1'b0)
            begin bad++; $display("FAIL spur_no_eoi eoi=%h spur=%0b exp 00/0", end_of_interrupt, spurious); end
        auto_eoi = 1'b0;
    endtask

    task automatic test_reset_mid();
        auto_eoi = 1'b1; mode_8086 = 1'b1;
        write_ocw2(8'hC2);
        model_rot = 2;
        irr = 8'h01;
        tick();
        pulse_begin(); pulse_end(); pulse_begin();
        total++; if (ack_phase !== 2'd2) begin bad++; $display("FAIL midreset_setup phase=%0d exp=2", ack_phase); end
        reset = 1'b1; end_s = 1'b1;
        tick();
        reset = 1'b0; end_s = 1'b0; irr = 8'h00;
        model_rot = 7; model_raeoi = 1'b0;
        total++; if (ack_phase !== 2'd0 || interrupt !== 8'h00 || end_of_interrupt !== 8'h00 || int_out !== 1'b0 || priority_rotate !== 3'd7 || latch_in_service !== 1'b0)
            begin bad++; $display("FAIL midreset_outputs phase=%0d int=%h eoi=%h int_out=%0b rot=%0d latch=%0b", ack_phase, interrupt, end_of_interrupt, int_out, priority_rotate, latch_in_service); end
        tick();
        total++; if (end_of_interrupt !== 8'h00 || ack_phase !== 2'd0)
            begin bad++; $display("FAIL midreset_no_eoi eoi=%h phase=%0d exp 00/0", end_of_interrupt, ack_phase); end
        auto_eoi = 1'b0;
    endtask

    task automatic test_ocw2_random();
        for (int n = 0; n < 20; n++) begin
            logic [7:0] d, mask;
            bit         rot_en;
            int         rot_val;
            d   = {3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))};
            isr = ($urandom_range(0, 2) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
            model_ocw(d, isr, mask, rot_en, rot_val);
            if (rot_en) model_rot = rot_val;
            write_ocw2(d);
            total++; if (end_of_interrupt !== mask || priority_rotate !== 3'(model_rot))
                begin bad++; $display("FAIL ocw2_cmd d=%h isr=%h eoi=%h rot=%0d exp %h/%0d", d, isr, end_of_interrupt, priority_rotate, mask, model_rot); end
            tick();
            total++; if (end_of_interrupt !== 8'h00) begin bad++; $display("FAIL ocw2_eoi_once d=%h got=%h exp=00", d, end_of_interrupt); end
        end
        isr = 8'h00;
    endtask

    task automatic test_random_ack();
        for (int n = 0; n < 40; n++) begin
            int         exp_lvl, sel, rot_val;
            logic [7:0] exp_oh, mask, d, exp_eoi;
            bit         rot_en;
            irr = 8'h00; isr = 8'h00;
            write_ocw2({5'b11000, 3'($urandom_range(0, 7))});
            model_rot = int'(ocw2_data[2:0]);
            d = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
            model_ocw(d, isr, mask, rot_en, rot_val);
            write_ocw2(d);
            mode_8086 = 1'($urandom_range(0, 1));
            auto_eoi  = 1'($urandom_range(0, 1));
            imr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            isr = ($urandom_range(0, 1) == 0) ? 8'h00 : (8'h01 << $urandom_range(0, 7));
            irr = 8'($urandom);
            tick(); tick();
            exp_lvl = model_resolve(irr & ~imr, isr, model_rot);
            total++; if (int_out !== (exp_lvl >= 0))
                begin bad++; $display("FAIL rnd_int_out irr=%h imr=%h isr=%h rot=%0d got=%0b exp=%0b", irr, imr, isr, model_rot, int_out, exp_lvl >= 0); end
            if (exp_lvl < 0) begin
                pulse_begin();
                total++; if (ack_phase !== 2'd0 || latch_in_service !== 1'b0)
                    begin bad++; $display("FAIL rnd_ignored_begin phase=%0d latch=%0b exp 0/0", ack_phase, latch_in_service); end
                continue;
            end
            exp_oh = 8'h01 << exp_lvl;
            pulse_begin();
            total++; if (interrupt !== exp_oh || clear_request !== exp_oh || latch_in_service !== 1'b1 || ack_level !== 3'(exp_lvl))
                begin bad++; $display("FAIL rnd_resolve irr=%h imr=%h isr=%h rot=%0d int=%h clr=%h lvl=%0d exp=%h", irr, imr, isr, model_rot, interrupt, clear_request, ack_level, exp_oh); end
            pulse_end(); pulse_begin();
            if (!mode_8086) begin pulse_end(); pulse_begin(); end
            // final INTA rising edge, optionally alongside an OCW2 command
            sel = $urandom_range(0, 3);
            d = (sel == 1) ? 8'h20 : (sel == 2) ? 8'hA0 : {5'b01100, 3'($urandom_range(0, 7))};
            mask = '0; rot_en = 1'b0; rot_val = 0;
            if (sel != 0) model_ocw(d, isr, mask, rot_en, rot_val);
            exp_eoi = mask | (auto_eoi ? exp_oh : 8'h00);
            if (rot_en) model_rot = rot_val;
            else if (auto_eoi && model_raeoi) model_rot = exp_lvl;
            end_s = 1'b1; ocw2_write = (sel != 0); ocw2_data = d;
            tick();
            end_s = 1'b0; ocw2_write = 1'b0; irr = 8'h00;
            total++; if (end_of_interrupt !== exp_eoi || priority_rotate !== 3'(model_rot))
                begin bad++; $display("FAIL rnd_final lvl=%0d aeoi=%0b raeoi=%0b ocw=%0d eoi=%h rot=%0d exp %h/%0d", exp_lvl, auto_eoi, model_raeoi, sel, end_of_interrupt, priority_rotate, exp_eoi, model_rot); end
            total++; if (interrupt !== 8'h00 || ack_phase !== 2'd0)
                begin bad++; $display("FAIL rnd_idle int=%h phase=%0d exp 00/0", interrupt, ack_phase); end
        end
        auto_eoi = 1'b0; mode_8086 = 1'b1; imr = 8'h00; isr = 8'h00;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_8086();
        test_isr_block();
        test_8080_aeoi();
        test_ocw2_rotate();
        test_spurious();
        test_reset_mid();
        test_ocw2_random();
        test_random_ack();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
